// File: rtl/loss_pkg.sv
// Shared constants and state encoding for the loss-stage target feeder.
package loss_pkg;

    localparam int DATA_W        = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/target_store.sv
// Target-pair storage: one write port, two independently addressed registered read ports.
module target_store #(
    parameter int DEPTH  = loss_pkg::DEFAULT_DEPTH,
    parameter int DATA_W = loss_pkg::DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_y_1,
    input  logic signed [DATA_W-1:0] wr_y_2,
    input  logic                     rd_en_1,
    input  logic [AW-1:0]            rd_addr_1,
    output logic signed [DATA_W-1:0] rd_y_1,
    input  logic                     rd_en_2,
    input  logic [AW-1:0]            rd_addr_2,
    output logic signed [DATA_W-1:0] rd_y_2
);

    logic signed [DATA_W-1:0] mem_y_1 [DEPTH];
    logic signed [DATA_W-1:0] mem_y_2 [DEPTH];

    // NOTE: the array has no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_y_1[wr_addr] <= wr_y_1;
            mem_y_2[wr_addr] <= wr_y_2;
        end
    end

    // Read registers only update on a read, so they hold the last row otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_y_1 <= '0;
            rd_y_2 <= '0;
        end else begin
            if (rd_en_1) rd_y_1 <= mem_y_1[rd_addr_1];
            if (rd_en_2) rd_y_2 <= mem_y_2[rd_addr_2];
        end
    end

endmodule

// File: rtl/loss_target_feeder.sv
// Buffers host-loaded target pairs and streams them, one batch at a time, alongside
// two independently timed activation columns toward the loss stage.
module loss_target_feeder #(
    parameter int DEPTH  = loss_pkg::DEFAULT_DEPTH,
    parameter int DATA_W = loss_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid_in,
    input  logic signed [DATA_W-1:0]  load_Y_1_in,
    input  logic signed [DATA_W-1:0]  load_Y_2_in,
    output logic                      load_ready_out,
    input  logic [$clog2(DEPTH):0]    batch_size_in,
    input  logic                      start_in,
    input  logic signed [DATA_W-1:0]  H_1_in,
    input  logic signed [DATA_W-1:0]  H_2_in,
    input  logic                      valid_1_in,
    input  logic                      valid_2_in,
    output logic signed [DATA_W-1:0]  H_1_out,
    output logic signed [DATA_W-1:0]  Y_1_out,
    output logic signed [DATA_W-1:0]  H_2_out,
    output logic signed [DATA_W-1:0]  Y_2_out,
    output logic                      valid_1_out,
    output logic                      valid_2_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      underflow_err_out
);

    import loss_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    state_t        state, state_next;
    logic [PW-1:0] wr_ptr, rd_1, rd_2;
    logic [PW-1:0] fill_1, fill_2, count;
    logic [PW-1:0] batch, rows_1, rows_2;
    logic          load_accept, start_accept, fire_1, fire_2, batch_end;

    // Pointers carry one extra bit so a full buffer is distinguishable from empty.
    assign fill_1 = wr_ptr - rd_1;
    assign fill_2 = wr_ptr - rd_2;
    assign count  = (fill_1 > fill_2) ? fill_1 : fill_2;

    assign load_ready_out = (state == IDLE) && (count < DEPTH_P);
    assign load_accept    = load_valid_in && load_ready_out;
    assign start_accept   = (state == IDLE) && start_in && (batch_size_in != '0)
                            && (batch_size_in <= count);
    assign fire_1         = (state == STREAM) && valid_1_in && (rows_1 < batch);
    assign fire_2         = (state == STREAM) && valid_2_in && (rows_2 < batch);
    assign batch_end      = (state == STREAM) && (rows_1 == batch) && (rows_2 == batch);
    assign busy_out       = (state == STREAM);

    // NOTE: next-state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start_accept) state_next = STREAM;
            STREAM: if (batch_end)    state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_1              <= '0;
            rd_2              <= '0;
            batch             <= '0;
            rows_1            <= '0;
            rows_2            <= '0;
            H_1_out           <= '0;
            H_2_out           <= '0;
            valid_1_out       <= 1'b0;
            valid_2_out       <= 1'b0;
            done_out          <= 1'b0;
            underflow_err_out <= 1'b0;
        end else begin
            if (load_accept)  wr_ptr <= wr_ptr + PW'(1);
            if (start_accept) batch  <= batch_size_in;
            if (fire_1) begin
                rd_1    <= rd_1 + PW'(1);
                rows_1  <= rows_1 + PW'(1);
                H_1_out <= H_1_in;
            end
            if (fire_2) begin
                rd_2    <= rd_2 + PW'(1);
                rows_2  <= rows_2 + PW'(1);
                H_2_out <= H_2_in;
            end
            // Both columns are exhausted here, so no fire can collide with the clear.
            if (batch_end) begin
                rows_1 <= '0;
                rows_2 <= '0;
            end
            valid_1_out <= fire_1;
            valid_2_out <= fire_2;
            done_out    <= batch_end;
            if ((valid_1_in && !fire_1) || (valid_2_in && !fire_2))
                underflow_err_out <= 1'b1;
        end
    end

    target_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load_accept),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_y_1    (load_Y_1_in),
        .wr_y_2    (load_Y_2_in),
        .rd_en_1   (fire_1),
        .rd_addr_1 (rd_1[AW-1:0]),
        .rd_y_1    (Y_1_out),
        .rd_en_2   (fire_2),
        .rd_addr_2 (rd_2[AW-1:0]),
        .rd_y_2    (Y_2_out)
    );

endmodule

// File: tb/tb_loss_target_feeder.sv
// Directed bench for loss_target_feeder: FIFO-ordered targets, lag, wrap, reject, underflow, reset.
module tb_loss_target_feeder;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int BW     = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     load_valid_in;
    logic signed [DATA_W-1:0] load_Y_1_in, load_Y_2_in;
    logic                     load_ready_out;
    logic [BW-1:0]            batch_size_in;
    logic                     start_in;
    logic signed [DATA_W-1:0] H_1_in, H_2_in;
    logic                     valid_1_in, valid_2_in;
    logic signed [DATA_W-1:0] H_1_out, Y_1_out, H_2_out, Y_2_out;
    logic                     valid_1_out, valid_2_out;
    logic                     busy_out, done_out, underflow_err_out;

    int compared   = 0;
    int mismatched = 0;

    logic signed [DATA_W-1:0] q_y1[$];
    logic signed [DATA_W-1:0] q_y2[$];

    always #5 clk = ~clk;

    loss_target_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .load_valid_in     (load_valid_in),
        .load_Y_1_in       (load_Y_1_in),
        .load_Y_2_in       (load_Y_2_in),
        .load_ready_out    (load_ready_out),
        .batch_size_in     (batch_size_in),
        .start_in          (start_in),
        .H_1_in            (H_1_in),
        .H_2_in            (H_2_in),
        .valid_1_in        (valid_1_in),
        .valid_2_in        (valid_2_in),
        .H_1_out           (H_1_out),
        .Y_1_out           (Y_1_out),
        .H_2_out           (H_2_out),
        .Y_2_out           (Y_2_out),
        .valid_1_out       (valid_1_out),
        .valid_2_out       (valid_2_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .underflow_err_out (underflow_err_out)
    );

    task automatic load_pair(input logic signed [DATA_W-1:0] y1, input logic signed [DATA_W-1:0] y2);
        compared++;
        if (load_ready_out !== 1'b1) begin
            mismatched++;
            $display("FAIL load_ready before load y1=%h: got %b want 1", y1, load_ready_out);
        end
        load_valid_in = 1'b1;
        load_Y_1_in   = y1;
        load_Y_2_in   = y2;
        @(negedge clk);
        load_valid_in = 1'b0;
        q_y1.push_back(y1);
        q_y2.push_back(y2);
    endtask

    // Streams n rows on both columns every cycle, checking pairing, latency and done.
    task automatic stream_batch(input int n);
        logic signed [DATA_W-1:0] e1, e2, h1, h2;
        e1 = '0; e2 = '0;
        start_in      = 1'b1;
        batch_size_in = BW'(n);
        @(negedge clk);
        start_in = 1'b0;
        compared++;
        if (busy_out !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_after_start n=%0d: got %b want 1", n, busy_out);
        end
        for (int i = 0; i < n; i++) begin
            h1 = DATA_W'(16'h0010 + i);
            h2 = DATA_W'(16'h0020 + i);
            valid_1_in = 1'b1; H_1_in = h1;
            valid_2_in = 1'b1; H_2_in = h2;
            @(negedge clk);
            e1 = q_y1.pop_front();
            e2 = q_y2.pop_front();
            compared++;
            if ({valid_1_out, H_1_out, Y_1_out} !== {1'b1, h1, e1}) begin
                mismatched++;
                $display("FAIL col1_row%0d: got v=%b H=%h Y=%h want v=1 H=%h Y=%h",
                         i, valid_1_out, H_1_out, Y_1_out, h1, e1);
            end
            compared++;
            if ({valid_2_out, H_2_out, Y_2_out, done_out} !== {1'b1, h2, e2, 1'b0}) begin
                mismatched++;
                $display("FAIL col2_row%0d: got v=%b H=%h Y=%h done=%b want v=1 H=%h Y=%h done=0",
                         i, valid_2_out, H_2_out, Y_2_out, done_out, h2, e2);
            end
        end
        valid_1_in = 1'b0;
        valid_2_in = 1'b0;
        @(negedge clk);
        compared++;
        if ({done_out, busy_out, valid_1_out, valid_2_out, Y_1_out, Y_2_out}
            !== {1'b1, 1'b0, 1'b0, 1'b0, e1, e2}) begin
            mismatched++;
            $display("FAIL batch_end: got done=%b busy=%b v1=%b v2=%b Y1=%h Y2=%h want 1 0 0 0 %h %h",
                     done_out, busy_out, valid_1_out, valid_2_out, Y_1_out, Y_2_out, e1, e2);
        end
        @(negedge clk);
        compared++;
        if (done_out !== 1'b0) begin
            mismatched++;
            $display("FAIL done_single_pulse: got %b want 0", done_out);
        end
    endtask

    task automatic test_reset();
        compared++;
        if ({valid_1_out, valid_2_out, H_1_out, Y_1_out, H_2_out, Y_2_out,
             busy_out, done_out, underflow_err_out, load_ready_out} !== {70'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%b%b H1=%h Y1=%h H2=%h Y2=%h busy=%b done=%b err=%b rdy=%b want all 0, rdy=1",
                     valid_1_out, valid_2_out, H_1_out, Y_1_out, H_2_out, Y_2_out,
                     busy_out, done_out, underflow_err_out, load_ready_out);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({busy_out, done_out, underflow_err_out, load_ready_out} !== 4'b0001) begin
            mismatched++;
            $display("FAIL after_reset_release: got %b want 0001",
                     {busy_out, done_out, underflow_err_out, load_ready_out});
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++)
            load_pair(DATA_W'(256 * i), DATA_W'(-(256 * i)));
        stream_batch(4);
    endtask

    task automatic test_lag();
        logic signed [DATA_W-1:0] e;
        for (int i = 0; i < 4; i++)
            load_pair(DATA_W'(16'h0500 + i), DATA_W'(16'h0600 + i));
        start_in      = 1'b1;
        batch_size_in = BW'(4);
        @(negedge clk);
        start_in = 1'b0;
        for (int c = 0; c < 7; c++) begin
            valid_1_in = (c < 4);
            valid_2_in = (c >= 3);
            H_1_in     = DATA_W'(c);
            H_2_in     = DATA_W'(c + 64);
            @(negedge clk);
            if (c < 4) begin
                e = q_y1.pop_front();
                compared++;
                if ({valid_1_out, H_1_out, Y_1_out} !== {1'b1, DATA_W'(c), e}) begin
                    mismatched++;
                    $display("FAIL lag_col1_c%0d: got v=%b H=%h Y=%h want v=1 H=%h Y=%h",
                             c, valid_1_out, H_1_out, Y_1_out, DATA_W'(c), e);
                end
            end
            if (c >= 3) begin
                e = q_y2.pop_front();
                compared++;
                if ({valid_2_out, H_2_out, Y_2_out} !== {1'b1, DATA_W'(c + 64), e}) begin
                    mismatched++;
                    $display("FAIL lag_col2_c%0d: got v=%b H=%h Y=%h want v=1 H=%h Y=%h",
                             c, valid_2_out, H_2_out, Y_2_out, DATA_W'(c + 64), e);
                end
            end else begin
                compared++;
                if (valid_2_out !== 1'b0) begin
                    mismatched++;
                    $display("FAIL lag_col2_idle_c%0d: got %b want 0", c, valid_2_out);
                end
            end
            compared++;
            if (done_out !== 1'b0) begin
                mismatched++;
                $display("FAIL lag_early_done_c%0d: got %b want 0", c, done_out);
            end
        end
        valid_1_in = 1'b0;
        valid_2_in = 1'b0;
        @(negedge clk);
        compared++;
        if ({done_out, busy_out} !== 2'b10) begin
            mismatched++;
            $display("FAIL lag_done: got done=%b busy=%b want 1 0", done_out, busy_out);
        end
        @(negedge clk);
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++)
            load_pair(DATA_W'(16'h1000 + i), DATA_W'(16'h2000 + i));
        compared++;
        if (load_ready_out !== 1'b0) begin
            mismatched++;
            $display("FAIL full_ready: got %b want 0", load_ready_out);
        end
        load_valid_in = 1'b1;
        load_Y_1_in   = 16'h7777;
        load_Y_2_in   = 16'h7777;
        @(negedge clk);
        load_valid_in = 1'b0;
        compared++;
        if (load_ready_out !== 1'b0) begin
            mismatched++;
            $display("FAIL ninth_load_ready: got %b want 0", load_ready_out);
        end
        stream_batch(8);
        for (int i = 0; i < 6; i++)
            load_pair(DATA_W'(16'h3000 + i), DATA_W'(-(16'h3000 + i)));
        stream_batch(6);
    endtask

    task automatic test_reject();
        for (int i = 0; i < 3; i++)
            load_pair(DATA_W'(16'h0700 + i), DATA_W'(16'h0800 + i));
        start_in      = 1'b1;
        batch_size_in = BW'(5);
        @(negedge clk);
        compared++;
        if (busy_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reject_batch5_count3: got busy=%b want 0", busy_out);
        end
        batch_size_in = BW'(0);
        @(negedge clk);
        start_in = 1'b0;
        compared++;
        if (busy_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reject_batch0: got busy=%b want 0", busy_out);
        end
    endtask

    task automatic test_underflow();
        logic signed [DATA_W-1:0] e1, e2;
        load_pair(16'h0703, 16'h0803);
        start_in      = 1'b1;
        batch_size_in = BW'(4);
        @(negedge clk);
        start_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid_1_in = 1'b1;
            valid_2_in = (c < 4);
            @(negedge clk);
            if (c < 4) begin
                e1 = q_y1.pop_front();
                e2 = q_y2.pop_front();
                compared++;
                if ({valid_1_out, Y_1_out, valid_2_out, Y_2_out, underflow_err_out}
                    !== {1'b1, e1, 1'b1, e2, 1'b0}) begin
                    mismatched++;
                    $display("FAIL uf_row%0d: got v1=%b Y1=%h v2=%b Y2=%h err=%b want 1 %h 1 %h 0",
                             c, valid_1_out, Y_1_out, valid_2_out, Y_2_out, underflow_err_out, e1, e2);
                end
            end else begin
                compared++;
                if ({valid_1_out, underflow_err_out, done_out} !== 3'b011) begin
                    mismatched++;
                    $display("FAIL uf_fifth_valid: got v1=%b err=%b done=%b want 0 1 1",
                             valid_1_out, underflow_err_out, done_out);
                end
            end
        end
        valid_1_in = 1'b0;
        valid_2_in = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({underflow_err_out, done_out, busy_out} !== 3'b100) begin
            mismatched++;
            $display("FAIL uf_sticky: got err=%b done=%b busy=%b want 1 0 0",
                     underflow_err_out, done_out, busy_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            load_pair(DATA_W'(16'h0900 + i), DATA_W'(16'h0A00 + i));
        start_in      = 1'b1;
        batch_size_in = BW'(4);
        @(negedge clk);
        start_in   = 1'b0;
        valid_1_in = 1'b1;
        valid_2_in = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({valid_1_out, Y_1_out, busy_out} !== {1'b1, 16'h0901, 1'b1}) begin
            mismatched++;
            $display("FAIL mid_row1: got v1=%b Y1=%h busy=%b want 1 0901 1", valid_1_out, Y_1_out, busy_out);
        end
        valid_1_in = 1'b0;
        valid_2_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({valid_1_out, valid_2_out, H_1_out, Y_1_out, H_2_out, Y_2_out,
             busy_out, done_out, underflow_err_out, load_ready_out} !== {70'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL mid_reset_outputs: got v=%b%b Y1=%h Y2=%h busy=%b done=%b err=%b rdy=%b want 0, rdy=1",
                     valid_1_out, valid_2_out, Y_1_out, Y_2_out, busy_out, done_out,
                     underflow_err_out, load_ready_out);
        end
        rst = 1'b0;
        q_y1.delete();
        q_y2.delete();
        @(negedge clk);
        start_in      = 1'b1;
        batch_size_in = BW'(1);
        @(negedge clk);
        start_in = 1'b0;
        compared++;
        if ({busy_out, load_ready_out} !== 2'b01) begin
            mismatched++;
            $display("FAIL mid_reset_count0: got busy=%b rdy=%b want 0 1", busy_out, load_ready_out);
        end
        load_pair(16'h0B00, 16'h0C00);
        load_pair(16'h0B01, 16'h0C01);
        stream_batch(2);
    endtask

    initial begin
        rst           = 1'b1;
        load_valid_in = 1'b0;
        load_Y_1_in   = '0;
        load_Y_2_in   = '0;
        batch_size_in = '0;
        start_in      = 1'b0;
        H_1_in        = '0;
        H_2_in        = '0;
        valid_1_in    = 1'b0;
        valid_2_in    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_stream();
        test_lag();
        test_full_wrap();
        test_reject();
        test_underflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/loss_target_feeder.md
LOSS_TARGET_FEEDER -- requirements
Module: loss_target_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning target-pair storage entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed fixed-point word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load_valid_in  input  1  host offers one target pair.
REQ-006 load_Y_1_in, load_Y_2_in  input  DATA_W signed  column-1/column-2 targets of one row.
REQ-007 load_ready_out  output  1  pair accepted on a cycle where load_valid_in && load_ready_out.
REQ-008 batch_size_in  input  $clog2(DEPTH)+1  rows per batch, sampled on an accepted start.
REQ-009 start_in  input  1  request to begin streaming one batch.
REQ-010 H_1_in, H_2_in  input  DATA_W signed  activations per column; valid_1_in, valid_2_in  input  1  qualifiers (column 2 may lag column 1 by any number of cycles).
REQ-011 H_1_out, Y_1_out, H_2_out, Y_2_out  output  DATA_W signed; valid_1_out, valid_2_out  output  1  aligned pairs for the loss stage.
REQ-012 busy_out  output  1  high in STREAM; done_out  output  1  one-cycle end-of-batch pulse; underflow_err_out  output  1  sticky error.

Function
REQ-013 SHALL implement states IDLE and STREAM.
REQ-014 Storage: circular buffer of DEPTH pairs, one write pointer, independent read pointers rd_1/rd_2, pointers wrap modulo DEPTH.
REQ-015 count = entries written minus entries read by the slower column (rd_2 unless rd_1 is behind); load_ready_out = (state==IDLE) && count<DEPTH.
REQ-016 Accepted load writes both targets at the write pointer and advances it by 1.
REQ-017 IDLE -> STREAM when start_in && batch_size_in!=0 && batch_size_in<=count (count taken before any same-cycle write); batch_size_in latched; else start_in ignored.
REQ-018 Same-cycle load and start in IDLE: load accepted, start judged on pre-write count.
REQ-019 In STREAM, valid_k_in with rows_k<batch: next cycle valid_k_out=1, H_k_out=H_k_in, Y_k_out=entry at rd_k; rd_k and rows_k increment. Latency exactly 1 cycle.
REQ-020 In STREAM, valid_k_in with rows_k==batch: valid_k_out=0, underflow_err_out set, pointers unchanged.
REQ-021 valid_k_in in IDLE: valid_k_out=0, underflow_err_out set.
REQ-022 When valid_k_out=0, H_k_out and Y_k_out hold their previous values.
REQ-023 When rows_1==batch && rows_2==batch (including both reaching it in the same cycle): next cycle done_out=1 and state=IDLE; rows counters cleared; unread entries beyond the batch retained for the next batch.
REQ-024 Columns operate independently; simultaneous valid_1_in and valid_2_in both serviced in the same cycle.
REQ-025 underflow_err_out cleared only by rst.

Reset
REQ-026 rst asserted (any time, incl. mid-STREAM): state=IDLE, pointers/counters=0, storage treated empty, all outputs 0 except load_ready_out=1 once state is IDLE after reset.
REQ-027 Storage array contents need no reset; only pointers.

Structure
REQ-028 Shared package loss_pkg SHALL hold DATA_W, default DEPTH and the state enum (IDLE, STREAM).
REQ-029 One sub-module target_store SHALL hold the DEPTH x 2 x DATA_W array with one write port and two registered read ports.

Verification
REQ-030 Load 4 pairs (Y1=0x0100..0x0400, Y2=-0x0100..-0x0400), start batch 4, valid_1/valid_2 every cycle -> 4 outputs per column, 1-cycle latency, Y matches order, done_out pulses once.
REQ-031 Column 2 lags column 1 by 3 cycles -> Y_2_out still pairs rows 0..3 in order; done_out only after column 2's 4th output.
REQ-032 Load 8 pairs (full) -> load_ready_out=0 after 8th; 9th load not accepted; batch 8 then 6 more loads wrap pointers, next batch of 6 returns new data.
REQ-033 Start with batch 5 when count=3 -> stays IDLE, busy_out=0; batch 0 -> ignored.
REQ-034 5th valid_1_in in batch 4 -> valid_1_out=0, underflow_err_out=1 sticky until rst.
REQ-035 rst asserted mid-batch after 2 rows -> all outputs 0, count 0, load_ready_out=1; fresh load+batch runs correctly.
